// File: rtl/cdc_fifo_reader_pkg.sv
// Shared constants and helpers for the clock-crossing FIFO read-side logic.
package cdc_fifo_pkg;

    localparam int STATS_WIDTH      = 32;
    localparam int MIN_READER_DEPTH = 2;

    // Local buffer depth must be a power of two so the pointers wrap for free.
    function automatic bit depth_ok(input int d);
        return (d >= MIN_READER_DEPTH) && ((d & (d - 1)) == 0);
    endfunction

endpackage

// File: rtl/cdc_fifo_reader_if.sv
// FIFO read-side and downstream stream signals of the FIFO reader.
interface cdc_fifo_reader_if #(
    parameter int DATA_W = 32
);

    logic [DATA_W-1:0] fifo_read_data;
    logic              fifo_read_valid;
    logic              fifo_read_ack;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;

    // slave: the reader block; master: the FIFO plus downstream consumer.
    modport slave (
        input  fifo_read_data,
        input  fifo_read_valid,
        input  out_ready,
        output fifo_read_ack,
        output out_data,
        output out_valid
    );

    modport master (
        output fifo_read_data,
        output fifo_read_valid,
        output out_ready,
        input  fifo_read_ack,
        input  out_data,
        input  out_valid
    );

endinterface

// File: rtl/cdc_fifo_reader_ring.sv
// Single-clock ring buffer: register array, wrapping pointers and occupancy count.
module sync_ring_buffer
    import cdc_fifo_pkg::*;
#(
    parameter  int DATA_W = 32,
    parameter  int DEPTH  = 4,
    localparam int PTR_W  = $clog2(DEPTH),
    localparam int CNT_W  = PTR_W + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] rd_data,
    output logic [CNT_W-1:0]  count
);

    typedef logic [DATA_W-1:0] data_t;
    typedef logic [PTR_W-1:0]  ptr_t;
    typedef logic [CNT_W-1:0]  count_t;

    data_t  mem_q [DEPTH];
    ptr_t   wr_ptr_q, wr_ptr_d;
    ptr_t   rd_ptr_q, rd_ptr_d;
    count_t count_q, count_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = wr_ptr_q + ptr_t'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + ptr_t'(1);
        case ({push, pop})
            2'b10:   count_d = count_q + count_t'(1);
            2'b01:   count_d = count_q - count_t'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset: contents are only observed while count is non-zero.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= push_data;
    end

    assign rd_data = mem_q[rd_ptr_q];
    assign count   = count_q;

    a_depth_ok: assert property (@(posedge clk) depth_ok(DEPTH));
    a_no_overflow: assert property (@(posedge clk) disable iff (reset)
        !(push && (count_q == count_t'(DEPTH))));
    a_no_underflow: assert property (@(posedge clk) disable iff (reset)
        !(pop && (count_q == '0)));

endmodule

// File: rtl/cdc_fifo_reader.sv
// Read-side adapter turning the FIFO's look-ahead ack protocol into a valid/ready stream.
// Optional CDC_FIFO_READER_STATS_EN adds word_count and stall_count outputs.
module cdc_fifo_reader
    import cdc_fifo_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4
) (
    input logic               clk,
    input logic               reset,
    cdc_fifo_reader_if.slave  bus
`ifdef CDC_FIFO_READER_STATS_EN
    ,
    output logic [STATS_WIDTH-1:0] word_count,
    output logic [STATS_WIDTH-1:0] stall_count
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef logic [DATA_W-1:0] data_t;
    typedef logic [CNT_W-1:0]  count_t;

    logic   ack_q, ack_d;
    logic   land;
    logic   pop;
    count_t count;
    count_t fill;
    data_t  rd_data;

    // Ack looks only at local occupancy; out_ready never reaches fifo_read_ack.
    always_comb begin
        land  = bus.fifo_read_valid & ack_q;
        fill  = count + count_t'(land);
        ack_d = ~reset & (fill < count_t'(DEPTH));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) ack_q <= 1'b0;
        else       ack_q <= ack_d;
    end

    assign bus.fifo_read_ack = ack_d;
    assign bus.out_valid     = (count != '0);
    assign bus.out_data      = rd_data;
    assign pop               = bus.out_valid & bus.out_ready;

    sync_ring_buffer #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_buf (
        .clk       (clk),
        .reset     (reset),
        .push      (land),
        .push_data (bus.fifo_read_data),
        .pop       (pop),
        .rd_data   (rd_data),
        .count     (count)
    );

`ifdef CDC_FIFO_READER_STATS_EN
    typedef logic [STATS_WIDTH-1:0] stat_t;

    stat_t word_count_q, word_count_d;
    stat_t stall_count_q, stall_count_d;

    function automatic stat_t sat_inc(input stat_t v);
        return (&v) ? v : v + stat_t'(1);
    endfunction

    // A stall is upstream data waiting while the local buffer is full.
    always_comb begin
        word_count_d  = pop ? word_count_q + stat_t'(1) : word_count_q;
        stall_count_d = stall_count_q;
        if ((count == count_t'(DEPTH)) && bus.fifo_read_valid)
            stall_count_d = sat_inc(stall_count_q);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            word_count_q  <= '0;
            stall_count_q <= '0;
        end else begin
            word_count_q  <= word_count_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign word_count  = word_count_q;
    assign stall_count = stall_count_q;
`endif

endmodule

// File: tb/tb_cdc_fifo_reader.sv
// Scoreboard bench for cdc_fifo_reader with a behavioural FIFO model and a 3:7 write/read clock ratio.
// Also exercises the CDC_FIFO_READER_STATS_EN counters when that macro is defined.
module tb_cdc_fifo_reader;
    import cdc_fifo_pkg::*;

    localparam int DATA_W   = 32;
    localparam int DEPTH    = 4;
    localparam int N_RANDOM = 10000;

    logic clk  = 1'b0;
    logic wclk = 1'b0;
    logic reset;

    cdc_fifo_reader_if #(.DATA_W(DATA_W)) bus ();

`ifdef CDC_FIFO_READER_STATS_EN
    logic [STATS_WIDTH-1:0] word_count;
    logic [STATS_WIDTH-1:0] stall_count;
`endif

    cdc_fifo_reader #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
`ifdef CDC_FIFO_READER_STATS_EN
        ,
        .word_count  (word_count),
        .stall_count (stall_count)
`endif
    );

    always #3 clk = ~clk;
    initial begin
        #1;
        forever #7 wclk = ~wclk;
    end

    int checks = 0;
    int passed = 0;
    int popped = 0;
    int sent   = 0;
    bit rand_en = 1'b0;

    logic [DATA_W-1:0] fifo_q[$];
    logic [DATA_W-1:0] exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act === req) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    endtask

    task automatic push_word(input logic [DATA_W-1:0] w);
        fifo_q.push_back(w);
        exp_q.push_back(w);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || bus.out_valid) && n < budget) begin
            step();
            n++;
        end
        check(name, 64'(n >= budget), 64'(0));
    endtask

    // FIFO read port: commits the head on an acked edge, otherwise just peeks it.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.fifo_read_valid <= 1'b0;
        end else if (bus.fifo_read_ack) begin
            if (fifo_q.size() > 0) begin
                bus.fifo_read_data  <= fifo_q.pop_front();
                bus.fifo_read_valid <= 1'b1;
            end else begin
                bus.fifo_read_valid <= 1'b0;
            end
        end else begin
            bus.fifo_read_valid <= (fifo_q.size() > 0);
            if (fifo_q.size() > 0) bus.fifo_read_data <= fifo_q[0];
        end
    end

    always @(posedge wclk) begin
        if (rand_en && sent < N_RANDOM && $urandom_range(0, 9) < 7) begin
            push_word($urandom);
            sent++;
        end
    end

    logic              prev_stall = 1'b0;
    logic [DATA_W-1:0] prev_data  = '0;

    always @(negedge clk) begin
        if (reset) begin
            prev_stall <= 1'b0;
        end else begin
            if (prev_stall) begin
                check("hold_valid", 64'(bus.out_valid), 64'(1));
                check("hold_data", 64'(bus.out_data), 64'(prev_data));
            end
            if (bus.out_valid && bus.out_ready) begin
                check("word_expected", 64'(exp_q.size() != 0), 64'(1));
                if (exp_q.size() != 0) check("out_data", 64'(bus.out_data), 64'(exp_q.pop_front()));
                popped++;
            end
            prev_stall <= bus.out_valid && !bus.out_ready;
            prev_data  <= bus.out_data;
        end
    end

    initial begin
        int n;
        bus.out_ready = 1'b0;
        reset = 1'b0;
        #1 reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_ack", 64'(bus.fifo_read_ack), 64'(0));
        check("reset_valid", 64'(bus.out_valid), 64'(0));
        step();
        reset = 1'b0;

        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("idle_valid", 64'(bus.out_valid), 64'(0));
            check("idle_ack", 64'(bus.fifo_read_ack), 64'(1));
        end

        // Streaming: 16 words, first valid two cycles after the first acked cycle with data.
        step();
        bus.out_ready = 1'b1;
        for (int i = 0; i < 16; i++) push_word(DATA_W'(i));
        for (int k = 0; k < 19; k++) begin
            @(negedge clk);
            check($sformatf("stream_valid_%0d", k), 64'(bus.out_valid), 64'(k >= 2 && k < 18));
        end
        check("stream_drained", 64'(exp_q.size()), 64'(0));

        // Backpressure: buffer fills to DEPTH, ack drops, head word is held.
        step();
        bus.out_ready = 1'b0;
        for (int i = 0; i < 8; i++) push_word(DATA_W'(i));
        repeat (8) step();
        @(negedge clk);
        check("bp_ack", 64'(bus.fifo_read_ack), 64'(0));
        check("bp_valid", 64'(bus.out_valid), 64'(1));
        check("bp_data", 64'(bus.out_data), 64'(0));
        check("bp_fifo_left", 64'(fifo_q.size()), 64'(8 - DEPTH));
        step();
        bus.out_ready = 1'b1;
        wait_drain("bp_drain_timeout", 100);

        // Peek: 0xAA sits on the FIFO port while the buffer is full.
        step();
        bus.out_ready = 1'b0;
        for (int i = 0; i < 4; i++) push_word(DATA_W'(8'h10 + i));
        push_word(DATA_W'(8'hAA));
        repeat (8) step();
        @(negedge clk);
        check("peek_valid", 64'(bus.fifo_read_valid), 64'(1));
        check("peek_data", 64'(bus.fifo_read_data), 64'(8'hAA));
        check("peek_ack", 64'(bus.fifo_read_ack), 64'(0));
        check("peek_uncommitted", 64'(fifo_q.size()), 64'(1));
`ifdef CDC_FIFO_READER_STATS_EN
        check("stall_count_nonzero", 64'(stall_count != 0), 64'(1));
`endif
        step();
        bus.out_ready = 1'b1;
        wait_drain("peek_drain_timeout", 100);

        // Random: writes on wclk, random backpressure on clk.
        rand_en = 1'b1;
        n = 0;
        while (!(sent == N_RANDOM && exp_q.size() == 0) && n < 60000) begin
            step();
            bus.out_ready = 1'($urandom_range(0, 1));
            n++;
        end
        rand_en = 1'b0;
        check("random_timeout", 64'(n >= 60000), 64'(0));
        check("random_sent", 64'(sent), 64'(N_RANDOM));
        step();
        bus.out_ready = 1'b1;
        wait_drain("random_drain_timeout", 100);
`ifdef CDC_FIFO_READER_STATS_EN
        check("word_count", 64'(word_count), 64'(popped));
`endif

        // Reset with three words buffered.
        step();
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) push_word(DATA_W'(8'h50 + i));
        repeat (5) step();
        @(negedge clk);
        check("pre_reset_count", 64'(dut.u_buf.count_q), 64'(3));
        step();
        reset = 1'b1;
        exp_q.delete();
        fifo_q.delete();
        @(negedge clk);
        check("midreset_ack", 64'(bus.fifo_read_ack), 64'(0));
        check("midreset_valid", 64'(bus.out_valid), 64'(0));
`ifdef CDC_FIFO_READER_STATS_EN
        check("midreset_word_count", 64'(word_count), 64'(0));
`endif
        step();
        reset = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("post_reset_valid", 64'(bus.out_valid), 64'(0));
            check("post_reset_count", 64'(dut.u_buf.count_q), 64'(0));
            check("post_reset_ack", 64'(bus.fifo_read_ack), 64'(1));
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
